llander_thrust_ctrl: RTL and testbench

- Conditions the player controls into the Lunar Lander core's THRUST and rotate inputs.
- Takes the analog stick, D-pad/keyboard thrust requests and turn requests from the top level.
- Produces a registered 8-bit thrust value plus active-low rotate lines that feed LLANDER_TOP directly.
- Replaces the ad-hoc thrust counter and turn thresholds in the top-level glue with one clocked, reset-aware block.

---
 rtl/llander_thrust_ctrl.sv | 157 +++++++++++++++
 tb/tb_llander_thrust_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llander_thrust_ctrl.sv
// Lunar Lander thrust / rotate conditioner.
// Turns the analog stick, D-pad thrust requests and turn requests into the
// registered 8-bit THRUST value and active-low rotate lines for LLANDER_TOP.
// Analog mode: THRUST follows 127 - joy_y (clamped) with 2 cycles of latency.
// D-pad mode: a shared ramp register steps once per tick and feeds THRUST.
module llander_thrust_ctrl #(
   parameter int TICK_DIV   = 98425,
   parameter int THRUST_MAX = 254,
   parameter int TURN_ON    = 64,
   parameter int TURN_OFF   = 48
) (
   input  logic              clk_25,
   input  logic              RESET_L,
   input  logic              mode_dpad,
   input  logic signed [7:0] joy_y,
   input  logic signed [7:0] joy_x,
   input  logic              thr_up,
   input  logic              thr_down,
   input  logic              turn_l,
   input  logic              turn_r,
   output logic        [7:0] THRUST,
   output logic              ROT_LEFT_L,
   output logic              ROT_RIGHT_L
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic        [7:0] MAX8     = 8'(THRUST_MAX);
   localparam logic signed [8:0] MAX9     = 9'(THRUST_MAX);
   localparam logic signed [8:0] ON_P     = 9'(TURN_ON);
   localparam logic signed [8:0] OFF_P    = 9'(TURN_OFF);
   localparam logic signed [8:0] ON_N     = -ON_P;
   localparam logic signed [8:0] OFF_N    = -OFF_P;

   // Clamp a 9-bit signed thrust candidate into 0..THRUST_MAX.
   function automatic logic [7:0] sat_thrust(input logic signed [8:0] v);
      if (v > MAX9) begin
         return MAX8;
      end else if (v < 9'sd0) begin
         return 8'd0;
      end else begin
         return v[7:0];
      end
   endfunction

   // One ramp step; opposing or absent requests hold, both ends saturate.
   function automatic logic [7:0] ramp_step(input logic [7:0] r,
                                            input logic up,
                                            input logic dn);
      if (up && !dn) begin
         return (r >= MAX8) ? MAX8 : r + 8'd1;
      end else if (dn && !up) begin
         return (r == 8'd0) ? 8'd0 : r - 8'd1;
      end else begin
         return r;
      end
   endfunction

   logic        [7:0]       ana_q, ana_d;
   logic        [7:0]       ramp_q, ramp_d;
   logic        [7:0]       thrust_q, thrust_d;
   logic        [CNT_W-1:0] cnt_q, cnt_d;
   logic                    mode_q;
   logic                    hl_q, hl_d;
   logic                    hr_q, hr_d;
   logic                    rot_l_q, rot_l_d;
   logic                    rot_r_q, rot_r_d;

   logic signed [8:0]       joy_y9;
   logic signed [8:0]       joy_x9;
   logic signed [8:0]       ana_raw;
   logic                    tick;
   logic                    mode_rise;
   logic                    want_l;
   logic                    want_r;

   assign joy_y9 = joy_y;
   assign joy_x9 = joy_x;

   // Analog map, tick decode, mode handover and ramp next-state.
   always_comb begin
      ana_raw   = 9'sd127 - joy_y9;
      ana_d     = sat_thrust(ana_raw);
      tick      = (cnt_q == CNT_LAST);
      mode_rise = mode_dpad & ~mode_q;
      cnt_d     = cnt_q + CNT_W'(1);
      ramp_d    = ramp_q;
      if (mode_rise) begin
         // Handover wins over a coincident tick so the ramp starts from the
         // current stick value with a full tick period ahead of it.
         cnt_d  = '0;
         ramp_d = ana_q;
      end else if (tick) begin
         cnt_d  = '0;
         ramp_d = ramp_step(ramp_q, thr_up, thr_down);
      end
      thrust_d = mode_q ? ramp_q : ana_q;
   end

   // Turn hysteresis per direction and the rotate-line decode.
   always_comb begin
      hl_d = hl_q;
      if (joy_x9 < ON_N) begin
         hl_d = 1'b1;
      end else if (joy_x9 > OFF_N) begin
         hl_d = 1'b0;
      end
      hr_d = hr_q;
      if (joy_x9 > ON_P) begin
         hr_d = 1'b1;
      end else if (joy_x9 < OFF_P) begin
         hr_d = 1'b0;
      end
      want_l  = turn_l | hl_d;
      want_r  = turn_r | hr_d;
      // Conflicting requests cancel: neither line is pulled low.
      rot_l_d = ~(want_l & ~want_r);
      rot_r_d = ~(want_r & ~want_l);
   end

   // Thrust path registers: analog sample, ramp, tick counter, mode, output.
   always_ff @(posedge clk_25 or negedge RESET_L) begin
      if (!RESET_L) begin
         ana_q    <= 8'd0;
         ramp_q   <= 8'd0;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         thrust_q <= 8'd0;
      end else begin
         ana_q    <= ana_d;
         ramp_q   <= ramp_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_dpad;
         thrust_q <= thrust_d;
      end
   end

   // Rotate path registers: hysteresis flags and active-low outputs.
   always_ff @(posedge clk_25 or negedge RESET_L) begin
      if (!RESET_L) begin
         hl_q    <= 1'b0;
         hr_q    <= 1'b0;
         rot_l_q <= 1'b1;
         rot_r_q <= 1'b1;
      end else begin
         hl_q    <= hl_d;
         hr_q    <= hr_d;
         rot_l_q <= rot_l_d;
         rot_r_q <= rot_r_d;
      end
   end

   assign THRUST      = thrust_q;
   assign ROT_LEFT_L  = rot_l_q;
   assign ROT_RIGHT_L = rot_r_q;

endmodule

// File: tb/tb_llander_thrust_ctrl.sv
// Directed bench for llander_thrust_ctrl with a short tick period.
module tb_llander_thrust_ctrl;

   localparam int D = 8;

   logic              clk_25 = 1'b0;
   logic              RESET_L = 1'b1;
   logic              mode_dpad = 1'b0;
   logic signed [7:0] joy_y = 8'sd0;
   logic signed [7:0] joy_x = 8'sd0;
   logic              thr_up = 1'b0;
   logic              thr_down = 1'b0;
   logic              turn_l = 1'b0;
   logic              turn_r = 1'b0;
   logic        [7:0] THRUST;
   logic              ROT_LEFT_L;
   logic              ROT_RIGHT_L;

   int   checks = 0;
   int   failures = 0;
   logic seen255 = 1'b0;

   llander_thrust_ctrl #(
      .TICK_DIV  (D),
      .THRUST_MAX(254),
      .TURN_ON   (64),
      .TURN_OFF  (48)
   ) dut (
      .clk_25     (clk_25),
      .RESET_L    (RESET_L),
      .mode_dpad  (mode_dpad),
      .joy_y      (joy_y),
      .joy_x      (joy_x),
      .thr_up     (thr_up),
      .thr_down   (thr_down),
      .turn_l     (turn_l),
      .turn_r     (turn_r),
      .THRUST     (THRUST),
      .ROT_LEFT_L (ROT_LEFT_L),
      .ROT_RIGHT_L(ROT_RIGHT_L)
   );

   always #5 clk_25 = ~clk_25;

   always @(negedge clk_25) begin
      if (THRUST === 8'hFF) seen255 = 1'b1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_25);
         #1;
      end
   endtask

   task automatic test_reset;
      RESET_L = 1'b1;
      #1 RESET_L = 1'b0;
      #1;
      checks++;
      if (THRUST !== 8'd0) begin
         failures++;
         $display("FAIL reset_thrust: got %0d expected 0", THRUST);
      end
      checks++;
      if (ROT_LEFT_L !== 1'b1) begin
         failures++;
         $display("FAIL reset_rot_l: got %b expected 1", ROT_LEFT_L);
      end
      checks++;
      if (ROT_RIGHT_L !== 1'b1) begin
         failures++;
         $display("FAIL reset_rot_r: got %b expected 1", ROT_RIGHT_L);
      end
      joy_y = -8'sd128;
      step(2);
      checks++;
      if (THRUST !== 8'd0) begin
         failures++;
         $display("FAIL reset_hold: got %0d expected 0", THRUST);
      end
      joy_y = 8'sd0;
      RESET_L = 1'b1;
   endtask

   task automatic test_analog;
      logic signed [7:0] ys [5];
      logic        [7:0] ex [5];
      logic        [7:0] prev;
      ys[0] = -8'sd128; ex[0] = 8'd254;
      ys[1] = 8'sd127;  ex[1] = 8'd0;
      ys[2] = 8'sd0;    ex[2] = 8'd127;
      ys[3] = -8'sd127; ex[3] = 8'd254;
      ys[4] = -8'sd1;   ex[4] = 8'd128;
      step(3);
      checks++;
      if (THRUST !== 8'd127) begin
         failures++;
         $display("FAIL analog_idle: got %0d expected 127", THRUST);
      end
      prev = 8'd127;
      for (int i = 0; i < 5; i++) begin
         joy_y = ys[i];
         step(1);
         checks++;
         if (THRUST !== prev) begin
            failures++;
            $display("FAIL analog_latency[%0d]: got %0d expected %0d", i, THRUST, prev);
         end
         step(1);
         checks++;
         if (THRUST !== ex[i]) begin
            failures++;
            $display("FAIL analog_map[%0d]: got %0d expected %0d", i, THRUST, ex[i]);
         end
         prev = ex[i];
      end
   endtask

   task automatic test_ramp_up;
      int bad = 0;
      int first_m = -1;
      int first_got = 0;
      int first_exp = 0;
      int e;
      RESET_L = 1'b0;
      mode_dpad = 1'b1;
      thr_up = 1'b1;
      thr_down = 1'b0;
      joy_y = 8'sd0;
      step(1);
      RESET_L = 1'b1;
      for (int m = 0; m <= 264 * D; m++) begin
         step(1);
         e = (m == 0) ? 0 : (m - 1) / D;
         if (e > 254) e = 254;
         if (int'(THRUST) != e) begin
            if (bad == 0) begin
               first_m = m;
               first_got = int'(THRUST);
               first_exp = e;
            end
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL ramp_up_seq: cycle %0d got %0d expected %0d (%0d bad cycles)",
                  first_m, first_got, first_exp, bad);
      end
      checks++;
      if (THRUST !== 8'd254) begin
         failures++;
         $display("FAIL ramp_up_top: got %0d expected 254", THRUST);
      end
   endtask

   task automatic test_ramp_down;
      int bad_step = 0;
      int bad_gap = 0;
      int changes = 0;
      int last_c = 0;
      logic [7:0] prev;
      thr_up = 1'b0;
      thr_down = 1'b1;
      prev = THRUST;
      for (int c = 1; c <= 270 * D; c++) begin
         step(1);
         if (THRUST !== prev) begin
            if (THRUST !== prev - 8'd1) bad_step++;
            if (changes > 0 && (c - last_c) != D) bad_gap++;
            last_c = c;
            changes++;
            prev = THRUST;
         end
      end
      checks++;
      if (bad_step != 0) begin
         failures++;
         $display("FAIL ramp_down_step: got %0d bad steps expected 0", bad_step);
      end
      checks++;
      if (bad_gap != 0) begin
         failures++;
         $display("FAIL ramp_down_period: got %0d bad intervals expected 0", bad_gap);
      end
      checks++;
      if (changes != 254) begin
         failures++;
         $display("FAIL ramp_down_count: got %0d steps expected 254", changes);
      end
      checks++;
      if (THRUST !== 8'd0) begin
         failures++;
         $display("FAIL ramp_down_floor: got %0d expected 0", THRUST);
      end
   endtask

   task automatic test_hold;
      int n = 0;
      int since;
      int bad = 0;
      thr_down = 1'b0;
      thr_up = 1'b1;
      while (THRUST !== 8'd100 && n < 120 * D) begin
         step(1);
         n++;
      end
      checks++;
      if (THRUST !== 8'd100) begin
         failures++;
         $display("FAIL hold_reach: got %0d expected 100", THRUST);
      end
      since = 1;
      thr_down = 1'b1;
      for (int i = 0; i < 5 * D; i++) begin
         step(1);
         since++;
         if (THRUST !== 8'd100) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL hold_both: got %0d off cycles expected 0", bad);
      end
      while (((since + 1) % D) == 0) begin
         step(1);
         since++;
      end
      thr_up = 1'b0;
      step(1);
      thr_up = 1'b1;
      step(2 * D);
      checks++;
      if (THRUST !== 8'd100) begin
         failures++;
         $display("FAIL hold_glitch: got %0d expected 100", THRUST);
      end
   endtask

   task automatic test_handover;
      int bad = 0;
      mode_dpad = 1'b0;
      thr_up = 1'b0;
      thr_down = 1'b0;
      joy_y = -8'sd60;
      step(2);
      checks++;
      if (THRUST !== 8'd187) begin
         failures++;
         $display("FAIL fall_follow: got %0d expected 187", THRUST);
      end
      step(2);
      mode_dpad = 1'b1;
      thr_up = 1'b1;
      for (int m = 0; m <= D; m++) begin
         step(1);
         if (THRUST !== 8'd187) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL handover_flat: got %0d off cycles expected 0", bad);
      end
      step(1);
      checks++;
      if (THRUST !== 8'd188) begin
         failures++;
         $display("FAIL handover_step: got %0d expected 188", THRUST);
      end
      thr_up = 1'b0;
   endtask

   task automatic test_turn;
      logic signed [7:0] xs [11];
      logic        [1:0] ex [11];
      xs[0]  = 8'sd0;   ex[0]  = 2'b11;
      xs[1]  = -8'sd64; ex[1]  = 2'b11;
      xs[2]  = -8'sd65; ex[2]  = 2'b01;
      xs[3]  = -8'sd50; ex[3]  = 2'b01;
      xs[4]  = -8'sd48; ex[4]  = 2'b01;
      xs[5]  = -8'sd47; ex[5]  = 2'b11;
      xs[6]  = 8'sd64;  ex[6]  = 2'b11;
      xs[7]  = 8'sd65;  ex[7]  = 2'b10;
      xs[8]  = 8'sd50;  ex[8]  = 2'b10;
      xs[9]  = 8'sd48;  ex[9]  = 2'b10;
      xs[10] = 8'sd47;  ex[10] = 2'b11;
      for (int i = 0; i < 11; i++) begin
         joy_x = xs[i];
         step(2);
         checks++;
         if ({ROT_LEFT_L, ROT_RIGHT_L} !== ex[i]) begin
            failures++;
            $display("FAIL turn_hyst[%0d] x=%0d: got %b expected %b",
                     i, xs[i], {ROT_LEFT_L, ROT_RIGHT_L}, ex[i]);
         end
      end
      joy_x = -8'sd100;
      step(1);
      checks++;
      if ({ROT_LEFT_L, ROT_RIGHT_L} !== 2'b01) begin
         failures++;
         $display("FAIL turn_latency: got %b expected 01", {ROT_LEFT_L, ROT_RIGHT_L});
      end
      joy_x = 8'sd0;
      step(2);
      turn_l = 1'b1;
      step(1);
      checks++;
      if ({ROT_LEFT_L, ROT_RIGHT_L} !== 2'b01) begin
         failures++;
         $display("FAIL turn_dig_l: got %b expected 01", {ROT_LEFT_L, ROT_RIGHT_L});
      end
      turn_l = 1'b0;
      turn_r = 1'b1;
      step(1);
      checks++;
      if ({ROT_LEFT_L, ROT_RIGHT_L} !== 2'b10) begin
         failures++;
         $display("FAIL turn_dig_r: got %b expected 10", {ROT_LEFT_L, ROT_RIGHT_L});
      end
      turn_l = 1'b1;
      step(1);
      checks++;
      if ({ROT_LEFT_L, ROT_RIGHT_L} !== 2'b11) begin
         failures++;
         $display("FAIL turn_dig_both: got %b expected 11", {ROT_LEFT_L, ROT_RIGHT_L});
      end
      turn_r = 1'b0;
      joy_x = 8'sd100;
      step(2);
      checks++;
      if ({ROT_LEFT_L, ROT_RIGHT_L} !== 2'b11) begin
         failures++;
         $display("FAIL turn_mixed: got %b expected 11", {ROT_LEFT_L, ROT_RIGHT_L});
      end
      turn_l = 1'b0;
      joy_x = 8'sd0;
      step(2);
   endtask

   task automatic test_reset_mid;
      int n = 0;
      int bad = 0;
      int e;
      mode_dpad = 1'b1;
      thr_up = 1'b0;
      thr_down = 1'b1;
      while (THRUST !== 8'd80 && n < 200 * D) begin
         step(1);
         n++;
      end
      checks++;
      if (THRUST !== 8'd80) begin
         failures++;
         $display("FAIL mid_reach: got %0d expected 80", THRUST);
      end
      turn_l = 1'b1;
      step(1);
      checks++;
      if (ROT_LEFT_L !== 1'b0) begin
         failures++;
         $display("FAIL mid_pre_rot: got %b expected 0", ROT_LEFT_L);
      end
      #2 RESET_L = 1'b0;
      #1;
      checks++;
      if ({THRUST, ROT_LEFT_L, ROT_RIGHT_L} !== {8'd0, 2'b11}) begin
         failures++;
         $display("FAIL mid_async: got thrust=%0d rot=%b%b expected thrust=0 rot=11",
                  THRUST, ROT_LEFT_L, ROT_RIGHT_L);
      end
      turn_l = 1'b0;
      thr_down = 1'b0;
      thr_up = 1'b1;
      step(1);
      RESET_L = 1'b1;
      for (int m = 0; m <= 2 * D + 1; m++) begin
         step(1);
         e = (m == 0) ? 0 : (m - 1) / D;
         if (int'(THRUST) != e) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL mid_restart: got %0d off cycles expected 0", bad);
      end
      checks++;
      if (THRUST !== 8'd2) begin
         failures++;
         $display("FAIL mid_restart_val: got %0d expected 2", THRUST);
      end
   endtask

   initial begin
      test_reset();
      test_analog();
      test_ramp_up();
      test_ramp_down();
      test_hold();
      test_handover();
      test_turn();
      test_reset_mid();
      checks++;
      if (seen255 !== 1'b0) begin
         failures++;
         $display("FAIL never_255: got %b expected 0", seen255);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
